// File: rtl/kgp_risc.sv
`default_nettype none
// =====================================================================
// kgp_risc : single-cycle 32-bit KGP-RISC core with internal ROM, RAM,
//            32x32 register file and carry flag; rout mirrors writeback.
// Optional : define KGP_RISC_HALT_EN to decode op 6'b111111 as HALT.
// Revision : 1.0
// =====================================================================
module kgp_risc #(
  parameter int    IMEM_DEPTH = 256,
  parameter int    DMEM_DEPTH = 256,
  parameter string IMEM_FILE  = "program.mem"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rout
);
  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_COMPI = 6'd2;
  localparam logic [5:0] OP_LW    = 6'd3;
  localparam logic [5:0] OP_SW    = 6'd4;
  localparam logic [5:0] OP_B     = 6'd5;
  localparam logic [5:0] OP_BR    = 6'd6;
  localparam logic [5:0] OP_BLTZ  = 6'd7;
  localparam logic [5:0] OP_BZ    = 6'd8;
  localparam logic [5:0] OP_BNZ   = 6'd9;
  localparam logic [5:0] OP_BL    = 6'd10;
  localparam logic [5:0] OP_BCY   = 6'd11;
  localparam logic [5:0] OP_BNCY  = 6'd12;
`ifdef KGP_RISC_HALT_EN
  localparam logic [5:0] OP_HALT  = 6'd63;
`endif

  localparam logic [5:0] FN_ADD   = 6'd0;
  localparam logic [5:0] FN_COMP  = 6'd1;
  localparam logic [5:0] FN_AND   = 6'd2;
  localparam logic [5:0] FN_XOR   = 6'd3;
  localparam logic [5:0] FN_SHLL  = 6'd4;
  localparam logic [5:0] FN_SHRL  = 6'd5;
  localparam logic [5:0] FN_SHLLV = 6'd6;
  localparam logic [5:0] FN_SHRLV = 6'd7;
  localparam logic [5:0] FN_SHRA  = 6'd8;
  localparam logic [5:0] FN_SHRAV = 6'd9;

  logic [31:0]     imem   [IMEM_DEPTH];
  logic [31:0]     dmem   [DMEM_DEPTH];
  logic [31:0]     r_regs [32];
  logic [PC_W-1:0] r_pc;
  logic            r_carry;

  logic [31:0]     w_instr;
  logic [5:0]      w_op;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [15:0]     w_imm;
  logic [4:0]      w_shamt;
  logic [5:0]      w_funct;
  logic [31:0]     w_rs_val;
  logic [31:0]     w_rt_val;
  logic [31:0]     w_simm;
  logic [31:0]     w_add_b;
  logic [32:0]     w_sum;
  logic [DA_W-1:0] w_addr;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_target;

  assign w_instr  = imem[r_pc];
  assign w_op     = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_imm    = w_instr[15:0];
  assign w_shamt  = w_instr[15:11];
  assign w_funct  = w_instr[5:0];
  assign w_target = PC_W'(w_instr[25:0]);
  assign w_rs_val = r_regs[w_rs];
  assign w_rt_val = r_regs[w_rt];
  assign w_simm   = {{16{w_imm[15]}}, w_imm};
  // add and addi share one 33-bit adder so both produce the carry-out
  assign w_add_b  = (w_op == OP_RTYPE) ? w_rt_val : w_simm;
  assign w_sum    = {1'b0, w_rs_val} + {1'b0, w_add_b};
  assign w_addr   = DA_W'(w_rs_val + w_simm);
  assign w_pc_inc = r_pc + 1'b1;

  logic [PC_W-1:0] w_pc_next;
  logic            w_wr_en;
  logic [4:0]      w_wr_idx;
  logic [31:0]     w_wr_data;
  logic            w_carry_next;
  logic            w_mem_we;

  always_comb begin
    w_pc_next    = w_pc_inc;
    w_wr_en      = 1'b0;
    w_wr_idx     = w_rs;
    w_wr_data    = 32'd0;
    w_carry_next = r_carry;
    w_mem_we     = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_wr_en = 1'b1;
        case (w_funct)
          FN_ADD: begin
            w_wr_data    = w_sum[31:0];
            w_carry_next = w_sum[32];
          end
          FN_COMP:  w_wr_data = 32'd0 - w_rt_val;
          FN_AND:   w_wr_data = w_rs_val & w_rt_val;
          FN_XOR:   w_wr_data = w_rs_val ^ w_rt_val;
          FN_SHLL:  w_wr_data = w_rs_val << w_shamt;
          FN_SHRL:  w_wr_data = w_rs_val >> w_shamt;
          FN_SHLLV: w_wr_data = w_rs_val << w_rt_val[4:0];
          FN_SHRLV: w_wr_data = w_rs_val >> w_rt_val[4:0];
          FN_SHRA:  w_wr_data = $signed(w_rs_val) >>> w_shamt;
          FN_SHRAV: w_wr_data = $signed(w_rs_val) >>> w_rt_val[4:0];
          default:  w_wr_en   = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_wr_en      = 1'b1;
        w_wr_data    = w_sum[31:0];
        w_carry_next = w_sum[32];
      end
      OP_COMPI: begin
        w_wr_en   = 1'b1;
        w_wr_data = 32'd0 - w_simm;
      end
      OP_LW: begin
        w_wr_en   = 1'b1;
        w_wr_idx  = w_rt;
        w_wr_data = dmem[w_addr];
      end
      OP_SW:   w_mem_we  = 1'b1;
      OP_B:    w_pc_next = w_target;
      OP_BR:   w_pc_next = PC_W'(w_rs_val);
      OP_BLTZ: if (w_rs_val[31])       w_pc_next = PC_W'(w_imm);
      OP_BZ:   if (w_rs_val == 32'd0)  w_pc_next = PC_W'(w_imm);
      OP_BNZ:  if (w_rs_val != 32'd0)  w_pc_next = PC_W'(w_imm);
      OP_BL: begin
        w_wr_en   = 1'b1;
        w_wr_idx  = 5'd31;
        w_wr_data = 32'(w_pc_inc);
        w_pc_next = w_target;
      end
      OP_BCY:  if (r_carry)  w_pc_next = w_target;
      OP_BNCY: if (!r_carry) w_pc_next = w_target;
`ifdef KGP_RISC_HALT_EN
      OP_HALT: w_pc_next = r_pc;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= '0;
      r_carry <= 1'b0;
      rout    <= 32'd0;
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else begin
      r_pc    <= w_pc_next;
      r_carry <= w_carry_next;
      if (w_wr_en) begin
        r_regs[w_wr_idx] <= w_wr_data;
        rout             <= w_wr_data;
      end
    end
  end

  // RAM is not cleared by reset, but stores are suppressed while parked
  always_ff @(posedge clk) begin
    if (reset && w_mem_we) dmem[w_addr] <= w_rt_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_kgp_risc.sv
`default_nettype none
// tb_kgp_risc : directed and random-program checks of kgp_risc against an ISA-level model.
module tb_kgp_risc;
  localparam int IM = 256;
  localparam int DM = 256;
  localparam logic [31:0] FILL = 32'h3400_0000;  // opcode 13, undefined

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rout;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] prog   [IM];
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [DM];
  logic [31:0] m_rout;
  int          m_pc;
  bit          m_carry;

  logic [31:0] exp1 [24] = '{32'd5, 32'd7, 32'd12, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd1,
                             32'h8000_0000, 32'd1, 32'h8000_0000, 32'hF800_0000, 32'h0800_0000,
                             32'd5, 32'hFFFF_FFFB, 32'd3, 32'd3, 32'd3, 32'd20, 32'd20, 32'd20,
                             32'h1234, 32'h1234, 32'h1234};

  kgp_risc #(.IMEM_DEPTH(IM), .DMEM_DEPTH(DM), .IMEM_FILE("")) dut (
    .clk(clk), .reset(reset), .rout(rout));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rt_ins(input int fn, input int rd, input int rb, input int sh);
    return {6'd0, 5'(rd), 5'(rb), 5'(sh), 5'd0, 6'(fn)};
  endfunction
  function automatic logic [31:0] it_ins(input int op, input int ra, input int rb, input int imm);
    return {6'(op), 5'(ra), 5'(rb), 16'(imm)};
  endfunction
  function automatic logic [31:0] jt_ins(input int op, input int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  // arithmetic shift built from a logical shift plus sign fill
  function automatic logic [31:0] sra(input logic [31:0] a, input int sh);
    return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
  endfunction

  task automatic model_step();
    logic [31:0] ins, a, b, simm, res;
    logic [32:0] s;
    int op, rs, rt, fn, sh, npc, addr, wi, tgt;
    bit wr;
    ins  = prog[m_pc];
    op   = int'(ins[31:26]);
    rs   = int'(ins[25:21]);
    rt   = int'(ins[20:16]);
    sh   = int'(ins[15:11]);
    fn   = int'(ins[5:0]);
    tgt  = int'(ins[25:0]) % IM;
    simm = {{16{ins[15]}}, ins[15:0]};
    a    = m_regs[rs];
    b    = m_regs[rt];
    npc  = (m_pc + 1) % IM;
    addr = int'((a + simm) % DM);
    wr   = 1'b0;
    wi   = rs;
    res  = 32'd0;
    case (op)
      0: begin
        wr = 1'b1;
        case (fn)
          0: begin s = 33'(a) + 33'(b); res = s[31:0]; m_carry = s[32]; end
          1: res = 32'd0 - b;
          2: res = a & b;
          3: res = a ^ b;
          4: res = a << sh;
          5: res = a >> sh;
          6: res = a << b[4:0];
          7: res = a >> b[4:0];
          8: res = sra(a, sh);
          9: res = sra(a, int'(b[4:0]));
          default: wr = 1'b0;
        endcase
      end
      1: begin s = 33'(a) + 33'(simm); res = s[31:0]; m_carry = s[32]; wr = 1'b1; end
      2: begin res = 32'd0 - simm; wr = 1'b1; end
      3: begin res = m_mem[addr]; wi = rt; wr = 1'b1; end
      4: m_mem[addr] = b;
      5: npc = tgt;
      6: npc = int'(a % IM);
      7: if (a[31]) npc = int'(ins[15:0]) % IM;
      8: if (a == 0) npc = int'(ins[15:0]) % IM;
      9: if (a != 0) npc = int'(ins[15:0]) % IM;
      10: begin res = 32'(npc); wi = 31; wr = 1'b1; npc = tgt; end
      11: if (m_carry) npc = tgt;
      12: if (!m_carry) npc = tgt;
`ifdef KGP_RISC_HALT_EN
      63: npc = m_pc;
`endif
      default: ;
    endcase
    if (wr) begin
      m_regs[wi] = res;
      m_rout     = res;
    end
    m_pc = npc;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_pc = 0; m_carry = 1'b0; m_rout = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rout", rout, m_rout);
      check("pc", 32'(dut.r_pc), 32'(m_pc));
      check("carry", 32'(dut.r_carry), {31'd0, m_carry});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IM; i++) prog[i] = FILL;
  endtask

  task automatic push_prog();
    for (int i = 0; i < IM; i++) dut.imem[i] = prog[i];
  endtask

  function automatic int reg_pick();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_ins();
    int k, op, ra, rb;
    k  = int'($urandom_range(0, 19));
    ra = reg_pick();
    rb = reg_pick();
    if (k < 7) return rt_ins(int'($urandom_range(0, 11)), ra, rb, int'($urandom_range(0, 31)));
    if (k < 18) begin
      op = int'($urandom_range(1, 12));
      if (op == 3 || op == 4) return it_ins(op, ra, rb, int'($urandom_range(0, 15)));
      return it_ins(op, ra, rb, int'($urandom_range(0, 65535)));
    end
    return it_ins(int'($urandom_range(13, 63)), ra, rb, int'($urandom_range(0, 65535)));
  endfunction

  initial begin
    for (int i = 0; i < DM; i++) begin
      dut.dmem[i] = 32'd0;
      m_mem[i]    = 32'd0;
    end
    clear_prog();
    push_prog();
    reset = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      check("rout_in_reset", rout, 32'd0);
    end

    // directed program: arithmetic, carry branches, shifts, memory, link
    clear_prog();
    prog[0]  = it_ins(1, 1, 0, 5);
    prog[1]  = it_ins(1, 2, 0, 7);
    prog[2]  = rt_ins(0, 1, 2, 0);
    prog[3]  = it_ins(1, 6, 0, 'hFFFF);
    prog[4]  = it_ins(1, 6, 0, 1);
    prog[5]  = jt_ins(11, 7);
    prog[6]  = it_ins(1, 7, 0, 99);
    prog[7]  = jt_ins(12, 6);
    prog[8]  = it_ins(1, 8, 0, 1);
    prog[9]  = rt_ins(4, 8, 0, 31);
    prog[10] = it_ins(1, 9, 0, 1);
    prog[11] = rt_ins(4, 9, 0, 31);
    prog[12] = rt_ins(8, 8, 0, 4);
    prog[13] = rt_ins(5, 9, 0, 4);
    prog[14] = it_ins(1, 10, 0, 5);
    prog[15] = rt_ins(1, 3, 10, 0);
    prog[16] = it_ins(1, 4, 0, 3);
    prog[17] = it_ins(4, 0, 4, 10);
    prog[18] = it_ins(3, 0, 5, 10);
    prog[19] = jt_ins(10, 30);
    prog[20] = it_ins(1, 11, 0, 'h1234);
    prog[21] = jt_ins(5, 21);
    prog[30] = it_ins(8, 1, 0, 40);
    prog[31] = it_ins(6, 31, 0, 0);
    push_prog();
    reset = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cyc();
      check($sformatf("prog1_rout[%0d]", i), rout, exp1[i]);
      if (i == 2) check("carry_after_add", 32'(dut.r_carry), 32'd0);
      if (i == 4) check("carry_after_wrap", 32'(dut.r_carry), 32'd1);
      if (i == 5) check("bcy_taken_pc", 32'(dut.r_pc), 32'd7);
      if (i == 6) check("bncy_fallthru_pc", 32'(dut.r_pc), 32'd8);
      if (i == 19) check("bz_fallthru_pc", 32'(dut.r_pc), 32'd31);
      if (i == 20) check("br_return_pc", 32'(dut.r_pc), 32'd20);
    end

    // mid-program reset: state clears, RAM word 10 survives
    reset = 1'b0;
    cyc();
    check("rout_mid_reset", rout, 32'd0);
    clear_prog();
    prog[0] = it_ins(3, 0, 5, 10);
    prog[4] = jt_ins(10, 8);
    prog[8] = it_ins(6, 31, 0, 0);
    prog[5] = it_ins(9, 5, 0, 7);
    prog[7] = jt_ins(5, 7);
    push_prog();
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (i == 0) check("lw_after_reset", rout, 32'd3);
      if (i == 4) check("bl_link_rout", rout, 32'd5);
      if (i == 4) check("bl_target_pc", 32'(dut.r_pc), 32'd8);
      if (i == 5) check("br_link_pc", 32'(dut.r_pc), 32'd5);
      if (i == 6) check("bnz_taken_pc", 32'(dut.r_pc), 32'd7);
    end

`ifdef KGP_RISC_HALT_EN
    reset = 1'b0;
    clear_prog();
    prog[0] = it_ins(1, 1, 0, 9);
    prog[1] = 32'hFC00_0000;
    push_prog();
    cyc();
    reset = 1'b1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      cyc();
      check("halt_rout", rout, 32'd9);
      check("halt_pc", 32'(dut.r_pc), 32'd1);
    end
`endif

    // random programs over the whole ROM with occasional reset pulses
    for (int r = 0; r < 4; r++) begin
      reset = 1'b0;
      clear_prog();
      for (int i = 0; i < IM; i++) prog[i] = rand_ins();
      push_prog();
      cyc();
      reset = 1'b1;
      for (int c = 0; c < 400; c++) begin
        reset = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
        cyc();
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
